// File: rtl/fifo_sync_param.sv
// Single-clock first-word-fall-through FIFO with occupancy tracking, programmable
// almost-full/almost-empty thresholds, synchronous flush and a sticky overflow flag.
module fifo_sync_param #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     data_1_en,
  input  logic [WIDTH-1:0]         data_1,
  output logic                     buffer_full,
  output logic                     almost_full,
  input  logic                     data_2_ready,
  output logic [WIDTH-1:0]         data_2,
  output logic                     data_2_valid,
  output logic                     buffer_empty,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_LVL   = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_LVL   = (AW+1)'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level_q;
  logic             overflow_q;
  logic             push;
  logic             pop;

  // A full buffer refuses writes even when a pop frees a slot in the same cycle.
  assign push = data_1_en & ~buffer_full;
  assign pop  = data_2_valid & data_2_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else if (clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (data_1_en && buffer_full) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Storage carries no reset; only the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[wr_ptr] <= data_1;
    end
  end

  assign level        = level_q;
  assign overflow     = overflow_q;
  assign buffer_full  = (level_q == FULL_LVL);
  assign buffer_empty = (level_q == '0);
  assign data_2_valid = ~buffer_empty;
  assign almost_empty = (level_q <= AE_LVL);
  assign data_2       = data_2_valid ? mem[rd_ptr] : '0;

  generate
    if (AF_LEVEL == 0) begin : g_af_always
      assign almost_full = 1'b1;
    end else begin : g_af_cmp
      assign almost_full = (level_q >= AF_LVL);
    end
  endgenerate

endmodule
